// File: rtl/rgb_ycbcr_pkg.sv
// Shared widths, FSM state encoding, config address map and index helpers
// for the time-multiplexed RGB->YCbCr sequencer.
// Optional build macro: RGB_YCBCR_OFFSET_EN (adds offset registers at 9..11).
package rgb_ycbcr_pkg;

  localparam int COEF_W   = 29;
  localparam int PIX_W    = 25;
  localparam int ACC_W    = 30;
  localparam int OUT_W    = 16;
  localparam int NUM_COEF = 9;
  localparam int ADDR_W   = 4;

  localparam logic [ADDR_W-1:0] ADDR_C1   = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_C2   = 4'd1;
  localparam logic [ADDR_W-1:0] ADDR_C3   = 4'd2;
  localparam logic [ADDR_W-1:0] ADDR_C4   = 4'd3;
  localparam logic [ADDR_W-1:0] ADDR_C5   = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_C6   = 4'd5;
  localparam logic [ADDR_W-1:0] ADDR_C7   = 4'd6;
  localparam logic [ADDR_W-1:0] ADDR_C8   = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_C9   = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_OFS0 = 4'd9;
  localparam logic [ADDR_W-1:0] ADDR_OFS1 = 4'd10;
  localparam logic [ADDR_W-1:0] ADDR_OFS2 = 4'd11;

  // Highest writable config address in this build.
`ifdef RGB_YCBCR_OFFSET_EN
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_OFS2;
`else
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_C9;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Output row (accumulator) touched by product index idx (idx / 3).
  function automatic logic [1:0] mac_row(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd2: return 2'd0;
      4'd3, 4'd4, 4'd5: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  // Pixel channel used by product index idx (idx % 3): 0=r, 1=g, 2=b.
  function automatic logic [1:0] mac_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/rgb_ycbcr_if.sv
// Config, pixel-in and result-out signals of the sequencer bundled as one
// interface. The sequencer takes the slave view; its driver takes master.
interface rgb_ycbcr_if;
  import rgb_ycbcr_pkg::*;

  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  r;
  logic [PIX_W-1:0]  g;
  logic [PIX_W-1:0]  b;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  col_1;
  logic [OUT_W-1:0]  col_2;
  logic [OUT_W-1:0]  col_3;
  logic              busy;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, r, g, b, out_ready,
    input  cfg_err, in_ready, out_valid, col_1, col_2, col_3, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, r, g, b, out_ready,
    output cfg_err, in_ready, out_valid, col_1, col_2, col_3, busy
  );

endinterface

// File: rtl/rgb_ycbcr_mac.sv
// Shared multiply-accumulate: acc_out = acc_in + coef*pix, everything
// wrapping modulo 2^ACC_W. Purely combinational; the sequencer owns state.
module rgb_ycbcr_mac
  import rgb_ycbcr_pkg::*;
(
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [COEF_W-1:0] coef,
  input  logic [PIX_W-1:0]  pix,
  output logic [ACC_W-1:0]  acc_out
);

  // Only the low ACC_W bits of the product survive, and those depend only
  // on the low ACC_W bits of each operand, so the multiplier is ACC_W wide.
  function automatic logic [ACC_W-1:0] mul_wrap(input logic [COEF_W-1:0] c,
                                                 input logic [PIX_W-1:0]  p);
    return ACC_W'(c) * ACC_W'(p);
  endfunction

  function automatic logic [ACC_W-1:0] add_wrap(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] p);
    return a + p;
  endfunction

  assign acc_out = add_wrap(acc_in, mul_wrap(coef, pix));

endmodule

// File: rtl/rgb_ycbcr_seq.sv
// RGB->YCbCr sequencer: one pixel at a time, nine products through a single
// shared MAC (one per CALC cycle), results held in OUT until accepted.
// Optional build macro: RGB_YCBCR_OFFSET_EN -- per-output offset registers
// at cfg_addr 9..11 preload the accumulators on accept.
module rgb_ycbcr_seq
  import rgb_ycbcr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  rgb_ycbcr_if.slave  io
);

  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [COEF_W-1:0] coef_q [NUM_COEF];
  logic [COEF_W-1:0] coef_d [NUM_COEF];
  logic [PIX_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q [3];
  logic [ACC_W-1:0]  acc_d [3];
  logic              cfg_err_q, cfg_err_d;
`ifdef RGB_YCBCR_OFFSET_EN
  logic [OUT_W-1:0]  ofs_q [3];
  logic [OUT_W-1:0]  ofs_d [3];
`endif

  logic              cfg_ok;
  logic [1:0]        row, col;
  logic [ACC_W-1:0]  mac_acc_in, mac_acc_out;
  logic [COEF_W-1:0] mac_coef;
  logic [PIX_W-1:0]  mac_pix;

  rgb_ycbcr_mac u_mac (
    .acc_in  (mac_acc_in),
    .coef    (mac_coef),
    .pix     (mac_pix),
    .acc_out (mac_acc_out)
  );

  // MAC operand selection, config writes and FSM next-state.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    coef_d    = coef_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    acc_d     = acc_q;
`ifdef RGB_YCBCR_OFFSET_EN
    ofs_d     = ofs_q;
`endif

    row = mac_row(idx_q);
    col = mac_col(idx_q);
    case (row)
      2'd0:    mac_acc_in = acc_q[0];
      2'd1:    mac_acc_in = acc_q[1];
      default: mac_acc_in = acc_q[2];
    endcase
    mac_coef = coef_q[idx_q];
    case (col)
      2'd0:    mac_pix = r_q;
      2'd1:    mac_pix = g_q;
      default: mac_pix = b_q;
    endcase

    // Writes only land while idle and inside the address map; anything
    // else is dropped and flagged for one cycle.
    cfg_ok    = io.cfg_we && (state_q == IDLE) && (io.cfg_addr <= ADDR_LAST);
    cfg_err_d = io.cfg_we && !cfg_ok;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (cfg_ok && (io.cfg_addr == ADDR_W'(i))) coef_d[i] = io.cfg_data;
    end
`ifdef RGB_YCBCR_OFFSET_EN
    for (int i = 0; i < 3; i++) begin
      if (cfg_ok && (io.cfg_addr == ADDR_OFS0 + ADDR_W'(i)))
        ofs_d[i] = io.cfg_data[OUT_W-1:0];
    end
`endif

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          state_d = CALC;
          idx_d   = 4'd0;
          r_d     = io.r;
          g_d     = io.g;
          b_d     = io.b;
          for (int i = 0; i < 3; i++) begin
`ifdef RGB_YCBCR_OFFSET_EN
            acc_d[i] = ACC_W'(ofs_q[i]);
`else
            acc_d[i] = '0;
`endif
          end
        end
      end
      CALC: begin
        for (int i = 0; i < 3; i++) begin
          if (row == 2'(i)) acc_d[i] = mac_acc_out;
        end
        if (idx_q == 4'd8) begin
          state_d = OUT;
          idx_d   = 4'd0;
        end else begin
          idx_d   = idx_q + 4'd1;
        end
      end
      OUT: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, coefficient, pixel and accumulator registers; reset clears all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      coef_q    <= '{default: '0};
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      acc_q     <= '{default: '0};
      cfg_err_q <= 1'b0;
`ifdef RGB_YCBCR_OFFSET_EN
      ofs_q     <= '{default: '0};
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      coef_q    <= coef_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
`ifdef RGB_YCBCR_OFFSET_EN
      ofs_q     <= ofs_d;
`endif
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == OUT);
  assign io.busy      = (state_q != IDLE);
  assign io.cfg_err   = cfg_err_q;
  assign io.col_1     = acc_q[0][OUT_W-1:0];
  assign io.col_2     = acc_q[1][OUT_W-1:0];
  assign io.col_3     = acc_q[2][OUT_W-1:0];

endmodule

// File: tb/tb_rgb_ycbcr_seq.sv
// Directed bench for rgb_ycbcr_seq with a result scoreboard fed from an
// independent 64-bit reference model of the 3x3 transform.
// Honours RGB_YCBCR_OFFSET_EN when the design is built with it.
module tb_rgb_ycbcr_seq;
  import rgb_ycbcr_pkg::*;

  typedef struct packed {
    logic [OUT_W-1:0] c1;
    logic [OUT_W-1:0] c2;
    logic [OUT_W-1:0] c3;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_ycbcr_if bus ();

  rgb_ycbcr_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  exp_t              sb [$];
  logic [COEF_W-1:0] m_coef [NUM_COEF];
`ifdef RGB_YCBCR_OFFSET_EN
  logic [OUT_W-1:0]  m_ofs [3];
`endif
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [PIX_W-1:0] r, input logic [PIX_W-1:0] g,
                                 input logic [PIX_W-1:0] b);
    logic [63:0] acc [3];
    logic [63:0] px [3];
    px[0] = 64'(r);
    px[1] = 64'(g);
    px[2] = 64'(b);
    for (int n = 0; n < 3; n++) begin
`ifdef RGB_YCBCR_OFFSET_EN
      acc[n] = 64'(m_ofs[n]);
`else
      acc[n] = 64'd0;
`endif
      for (int k = 0; k < 3; k++)
        acc[n] = (acc[n] + ((64'(m_coef[3*n+k]) * px[k]) % (64'd1 << ACC_W))) % (64'd1 << ACC_W);
    end
    return '{c1: acc[0][OUT_W-1:0], c2: acc[1][OUT_W-1:0], c3: acc[2][OUT_W-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [COEF_W-1:0] d);
    if (a < 4'd9) m_coef[a] = d;
`ifdef RGB_YCBCR_OFFSET_EN
    else if (a < 4'd12) m_ofs[a - 4'd9] = d[OUT_W-1:0];
`endif
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [COEF_W-1:0] d,
                           input logic exp_err, input string tag);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = d;
    tick();
    bus.cfg_we   = 1'b0;
    check({tag, "_cfg_err"}, 64'(bus.cfg_err), 64'(exp_err));
    if (!exp_err) model_write(a, d);
  endtask

  task automatic accept(input logic [PIX_W-1:0] r, input logic [PIX_W-1:0] g,
                        input logic [PIX_W-1:0] b, input string tag);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.r = r;
    bus.g = g;
    bus.b = b;
    sb.push_back(model(r, g, b));
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_out(input int exp_lat, input string tag);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic take_out(input int hold, input string tag);
    exp_t e = '0;
    check({tag, "_sb_depth"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) e = sb.pop_front();
    check({tag, "_col_1"}, 64'(bus.col_1), 64'(e.c1));
    check({tag, "_col_2"}, 64'(bus.col_2), 64'(e.c2));
    check({tag, "_col_3"}, 64'(bus.col_3), 64'(e.c3));
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.r = '1;
      bus.g = '1;
      bus.b = '1;
      tick();
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'd0);
      check({tag, "_hold_cols"}, 64'({bus.col_1, bus.col_2, bus.col_3}), 64'(e));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
    bus.in_valid = 1'b0;
    bus.r = '0;
    bus.g = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_COEF; i++) m_coef[i] = '0;
`ifdef RGB_YCBCR_OFFSET_EN
    for (int i = 0; i < 3; i++) m_ofs[i] = '0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
    check("rst_cols", 64'({bus.col_1, bus.col_2, bus.col_3}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Identity diagonal, with a 4-cycle output stall
    cfg_write(ADDR_C1, 29'd1, 1'b0, "id_c1");
    cfg_write(ADDR_C5, 29'd1, 1'b0, "id_c5");
    cfg_write(ADDR_C9, 29'd1, 1'b0, "id_c9");
    accept(25'd5, 25'd7, 25'd9, "id");
    wait_out(9, "id");
    check("id_col_1_const", 64'(bus.col_1), 64'd5);
    check("id_col_3_const", 64'(bus.col_3), 64'd9);
    take_out(4, "id");

    // Product wraps to zero modulo 2^ACC_W
    cfg_write(ADDR_C1, 29'd1 << 20, 1'b0, "wrap_c1");
    accept(25'd1 << 12, 25'd0, 25'd0, "wrap");
    wait_out(9, "wrap");
    check("wrap_col_1_const", 64'(bus.col_1), 64'd0);
    take_out(0, "wrap");

    // Large pixel times small coefficients
    cfg_write(ADDR_C1, 29'd3, 1'b0, "big_c1");
    cfg_write(ADDR_C2, 29'd1, 1'b0, "big_c2");
    accept('1, 25'd4, 25'd0, "big");
    wait_out(9, "big");
    check("big_col_1_const", 64'(bus.col_1), 64'd1);
    take_out(0, "big");

    // All-ones operands everywhere
    for (int i = 0; i < NUM_COEF; i++) cfg_write(ADDR_W'(i), '1, 1'b0, "ones_c");
    accept('1, '1, '1, "ones");
    wait_out(9, "ones");
    take_out(1, "ones");

    // Write during CALC is dropped and flagged
    accept(25'd1, 25'd0, 25'd0, "calc");
    cfg_write(ADDR_C1, 29'd7, 1'b1, "calc_wr");
    tick();
    check("calc_err_drops", 64'(bus.cfg_err), 64'd0);
    wait_out(7, "calc");
    take_out(0, "calc");
    accept(25'd1, 25'd0, 25'd0, "calc_old");
    wait_out(9, "calc_old");
    check("calc_old_col_1_const", 64'(bus.col_1), 64'hFFFF);
    take_out(0, "calc_old");

    // Out-of-range addresses in IDLE
    cfg_write(4'd13, 29'd5, 1'b1, "bad13");
`ifndef RGB_YCBCR_OFFSET_EN
    cfg_write(ADDR_OFS0, 29'd5, 1'b1, "bad9");
`endif
    accept(25'd3, 25'd5, 25'd7, "bad");
    wait_out(9, "bad");
    take_out(0, "bad");

    // Write and accept on the same edge: new coefficient is used
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = ADDR_C4;
    bus.cfg_data = 29'd11;
    model_write(ADDR_C4, 29'd11);
    accept(25'd2, 25'd3, 25'd4, "same");
    bus.cfg_we = 1'b0;
    check("same_cfg_err", 64'(bus.cfg_err), 64'd0);
    wait_out(9, "same");
    take_out(0, "same");

    // Random coefficients and pixels
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NUM_COEF; i++) cfg_write(ADDR_W'(i), COEF_W'($urandom), 1'b0, "rnd_c");
      accept(PIX_W'($urandom), PIX_W'($urandom), PIX_W'($urandom), "rnd");
      wait_out(9, "rnd");
      take_out(t, "rnd");
    end

    // Asynchronous reset at CALC idx 4 discards the pixel and coefficients
    accept(25'd5, 25'd7, 25'd9, "rst");
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_cols", 64'({bus.col_1, bus.col_2, bus.col_3}), 64'd0);
    sb.delete();
    for (int i = 0; i < NUM_COEF; i++) m_coef[i] = '0;
`ifdef RGB_YCBCR_OFFSET_EN
    for (int i = 0; i < 3; i++) m_ofs[i] = '0;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_after_valid", 64'(bus.out_valid), 64'd0);
    accept(25'd5, 25'd7, 25'd9, "zero");
    wait_out(9, "zero");
    check("zero_cols_const", 64'({bus.col_1, bus.col_2, bus.col_3}), 64'd0);
    take_out(0, "zero");

`ifdef RGB_YCBCR_OFFSET_EN
    // Offset preload with zero coefficients
    cfg_write(ADDR_OFS1, 29'd128, 1'b0, "ofs1");
    cfg_write(4'd12, 29'd1, 1'b1, "bad12");
    accept(25'd5, 25'd7, 25'd9, "ofs");
    wait_out(9, "ofs");
    check("ofs_col_2_const", 64'(bus.col_2), 64'd128);
    take_out(0, "ofs");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
